// File: rtl/message_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63] through a 16-word sliding window.
// Optional build macro MSG_SCHED_KROM_EN adds the internal K ROM; without it Ki is tied to 0.
module message_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] block_in,
    output logic         ready,
    output logic         busy,
    output logic         load_digest,
    output logic         wi_valid,
    output logic [31:0]  Wi,
    output logic [31:0]  Ki,
    output logic [5:0]   round,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0][31:0] w_q, w_d;
    logic [5:0]        round_q, round_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              load_digest_q, load_digest_d;
    logic              wi_valid_q, wi_valid_d;
    logic              done_q, done_d;
    logic [31:0]       w_next;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // w[i] holds W[t+i]; the new tail word is W[t+16]
    assign w_next = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) w_d[i] = block_in[511-32*i -: 32];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                round_d = 6'd0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = w_next;
                if (round_q == 6'd63) state_d = S_DONE;
                else round_d = round_q + 6'd1;
            end
            S_DONE: begin
                round_d = 6'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Status outputs are decoded from the next state so they land registered
        ready_d       = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        load_digest_d = (state_d != S_ROUND);
        wi_valid_d    = (state_d == S_ROUND);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            w_q           <= '0;
            round_q       <= 6'd0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            load_digest_q <= 1'b1;
            wi_valid_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            round_q       <= round_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            load_digest_q <= load_digest_d;
            wi_valid_q    <= wi_valid_d;
            done_q        <= done_d;
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign load_digest = load_digest_q;
    assign wi_valid    = wi_valid_q;
    assign done        = done_q;
    assign round       = round_q;
    assign Wi          = w_q[0];

`ifdef MSG_SCHED_KROM_EN
    logic [31:0] k_rom;

    always_comb begin
        k_rom = 32'h0;
        case (round_q)
            6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
            6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
            6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
            6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
            6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
            6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
            6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
            6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
            6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
            6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
            6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
            6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
            6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
            6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
            6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
            6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
            6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
            6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
            6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
            6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
            6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
            6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
            6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
            6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
            6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
            6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
            6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
            6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
            6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
            6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
            6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
            6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
        endcase
    end

    // Constants are only presented while a round is live
    assign Ki = wi_valid_q ? k_rom : 32'h0;
`else
    assign Ki = 32'h0;
`endif

endmodule

// File: tb/tb_message_schedule.sv
// Bench for message_schedule: scoreboard of expected (W, t) per round, done timing and an
// attached SHA-256 compression model checked against the "abc" digest.
module tb_message_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] block_in;
    logic         ready, busy, load_digest, wi_valid, done;
    logic [31:0]  Wi, Ki;
    logic [5:0]   round;

    message_schedule dut (
        .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in),
        .ready(ready), .busy(busy), .load_digest(load_digest), .wi_valid(wi_valid),
        .Wi(Wi), .Ki(Ki), .round(round), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] H0 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] ABC_HASH [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                             32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

    typedef struct { logic [31:0] w; logic [5:0] r; } exp_t;
    typedef struct { int cyc; bit abc; } dn_t;

    exp_t        q[$];
    dn_t         dq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          last_acc = 0;
    int          last_gap = 0;
    logic [31:0] hs [8];
    exp_t        e;
    logic        exp_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule uses the textbook W[t] recurrence, not a window
    task automatic push_block(input logic [511:0] b);
        logic [31:0] w [64];
        exp_t        x;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            x.w = w[t];
            x.r = 6'(t);
            q.push_back(x);
        end
    endtask

    task automatic comp_round(input logic [31:0] w, input logic [31:0] k);
        logic [31:0] t1, t2;
        t1 = hs[7] + (rotr(hs[4], 6) ^ rotr(hs[4], 11) ^ rotr(hs[4], 25))
           + ((hs[4] & hs[5]) ^ (~hs[4] & hs[6])) + k + w;
        t2 = (rotr(hs[0], 2) ^ rotr(hs[0], 13) ^ rotr(hs[0], 22))
           + ((hs[0] & hs[1]) ^ (hs[0] & hs[2]) ^ (hs[1] & hs[2]));
        hs[7] = hs[6]; hs[6] = hs[5]; hs[5] = hs[4]; hs[4] = hs[3] + t1;
        hs[3] = hs[2]; hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = t1 + t2;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            dq.delete();
        end else begin
            chk("busy_vs_ready", {31'b0, busy}, {31'b0, !ready});
            chk("load_vs_valid", {31'b0, load_digest}, {31'b0, !wi_valid});
            if (!wi_valid) chk("ki_outside_round", Ki, 32'h0);
            exp_done = (dq.size() > 0) && (dq[0].cyc + 66 == cyc);
            chk("done_timing", {31'b0, done}, {31'b0, exp_done});
            if (done) chk("round_in_done", {26'b0, round}, 32'd63);
            if (exp_done) begin
                if (dq[0].abc)
                    for (int i = 0; i < 8; i++) chk("abc_digest", hs[i] + H0[i], ABC_HASH[i]);
                void'(dq.pop_front());
            end
            if (wi_valid) begin
                if (q.size() == 0) chk("wi_unexpected", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("wi", Wi, e.w);
                    chk("round", {26'b0, round}, {26'b0, e.r});
`ifdef MSG_SCHED_KROM_EN
                    chk("ki", Ki, KT[e.r]);
`else
                    chk("ki", Ki, 32'h0);
`endif
                    if (dq.size() > 0 && dq[0].abc)
                        case (e.r)
                            6'd0:  chk("abc_w0", Wi, 32'h61626380);
                            6'd15: chk("abc_w15", Wi, 32'h00000018);
                            6'd16: chk("abc_w16", Wi, 32'h61626380);
                            6'd17: chk("abc_w17", Wi, 32'h000f0000);
                            default: ;
                        endcase
                end
            end
            // Compression register file reacts to this cycle at the coming edge
            if (load_digest) for (int i = 0; i < 8; i++) hs[i] = H0[i];
            else comp_round(Wi, KT[round]);
            if (start && ready) begin
                push_block(block_in);
                dq.push_back('{cyc, block_in == ABC_BLK});
                acc_cnt++;
                last_gap = cyc - last_acc;
                last_acc = cyc;
            end
        end
    end

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
        return b;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("timeout_ready", {31'b0, ready}, 32'd1);
    endtask

    task automatic wait_round(input logic [5:0] r);
        int n = 0;
        while (!(wi_valid && round == r) && n < 200) begin @(posedge clk); #1; n++; end
        chk("timeout_round", {26'b0, round}, {26'b0, r});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin @(posedge clk); #1; n++; end
        chk("timeout_done", {31'b0, done}, 32'd1);
    endtask

    task automatic send(input logic [511:0] b);
        wait_ready();
        block_in = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        block_in = rand_blk();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_load"}, {31'b0, load_digest}, 32'd1);
        chk({tag, "_valid"}, {31'b0, wi_valid}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_wi"}, Wi, 32'd0);
        chk({tag, "_ki"}, Ki, 32'd0);
        chk({tag, "_round"}, {26'b0, round}, 32'd0);
    endtask

    int a0;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        block_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", {31'b0, ready}, 32'd1);
        chk("post_reset_load", {31'b0, load_digest}, 32'd1);

        send(ABC_BLK);
        send(rand_blk());
        send(rand_blk());
        send(32'h0);

        // Starts while busy must be ignored, including the done cycle
        send(ABC_BLK);
        wait_round(6'd0);
        pulse_start();
        wait_round(6'd30);
        pulse_start();
        wait_done();
        pulse_start();
        wait_ready();

        // start held high: back-to-back accepts every 67 cycles
        a0 = acc_cnt;
        block_in = rand_blk();
        start = 1'b1;
        repeat (201) begin
            @(posedge clk); #1;
            block_in = rand_blk();
        end
        start = 1'b0;
        chk("held_accepts", acc_cnt - a0, 32'd3);
        chk("held_gap", last_gap, 32'd67);
        wait_ready();

        // Asynchronous abort mid-block
        send(ABC_BLK);
        wait_round(6'd40);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(ABC_BLK);
        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", q.size(), 32'd0);
        chk("done_q_empty", dq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
